// File: rtl/secded_pkg.sv
// Shared SEC-DED helpers: check-width sizing, data-bit placement in the
// Hamming codeword and syndrome classification.
package secded_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'd0,
    ST_CORR   = 2'd1,
    ST_UNCORR = 2'd2
  } status_e;

  // Smallest r such that 2^r >= data_w + r + 1 (supports data_w up to 64).
  function automatic int ham_w(input int data_w);
    int r;
    r = 7;
    for (int k = 7; k >= 1; k--) begin
      if ((1 << k) >= data_w + k + 1) r = k;
    end
    return r;
  endfunction

  // Codeword position of data bit idx; positions start at 1, powers of two are skipped.
  function automatic int data_pos(input int idx);
    int pos;
    pos = idx + 1;
    for (int k = 0; k < 8; k++) begin
      if (pos >= (1 << k)) pos++;
    end
    return pos;
  endfunction

  function automatic status_e classify_syndrome(input logic par, input int syn, input int last_pos);
    status_e st;
    if (!par)
      st = (syn == 0) ? ST_CLEAN : ST_UNCORR;
    else if (syn > last_pos)
      st = ST_UNCORR;
    else
      st = ST_CORR;
    return st;
  endfunction

endpackage

// File: rtl/keyed_secded_corrector_pipe_if.sv
// Codeword-in / corrected-data-out stream pair with valid/ready on each side.
interface keyed_secded_corrector_pipe_if
  import secded_pkg::*;
#(
  parameter int DATA_W = 32
) ();
  localparam int CHK_W = ham_w(DATA_W) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_status;

  modport master (
    output in_valid, in_data, in_chk, out_ready,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_data, in_chk, out_ready,
    output in_ready, out_valid, out_data, out_status
  );
endinterface

// File: rtl/secded_syndrome_gen.sv
// Combinational Hamming syndrome and overall parity of a received codeword.
module secded_syndrome_gen
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int HAM_W  = ham_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [HAM_W:0]    chk,
  output logic [HAM_W-1:0]  syn,
  output logic              par
);
  logic [HAM_W-1:0] contrib [DATA_W];

  genvar gi;
  for (gi = 0; gi < DATA_W; gi++) begin : g_pos
    localparam int POS = data_pos(gi);
    assign contrib[gi] = data[gi] ? HAM_W'(POS) : '0;
  end

  always_comb begin
    syn = chk[HAM_W-1:0];
    for (int i = 0; i < DATA_W; i++) begin
      syn = syn ^ contrib[i];
    end
  end

  assign par = (^data) ^ (^chk);
endmodule

// File: rtl/keyed_secded_corrector_pipe.sv
// Two-stage SEC-DED corrector: stage 1 captures data and key-gated syndrome,
// stage 2 applies the correction and holds the result under backpressure.
module keyed_secded_corrector_pipe
  import secded_pkg::*;
#(
  parameter int                         DATA_W  = 32,
  parameter logic [ham_w(DATA_W)-1:0]   KEY_REF = '0,
  parameter int                         CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  keyed_secded_corrector_pipe_if.slave  bus,
  input  logic                          key_shift_en,
  input  logic                          key_bit,
  input  logic                          key_commit,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              corr_cnt,
  output logic [CNT_W-1:0]              uncorr_cnt
);
  localparam int HAM_W    = ham_w(DATA_W);
  localparam int LAST_POS = DATA_W + HAM_W;

  logic [HAM_W-1:0]  key_shreg_reg, key_shreg_next, active_key_reg;
  logic              s1_valid_reg, s1_par_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic [HAM_W-1:0]  s1_syn_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  status_e           out_status_reg;
  logic [CNT_W-1:0]  corr_cnt_reg, uncorr_cnt_reg;

  logic [HAM_W-1:0]  raw_syn;
  logic              raw_par;
  logic              s2_load, out_fire;
  logic [DATA_W-1:0] flip_mask, data_next;
  status_e           status_next;

  secded_syndrome_gen #(.DATA_W(DATA_W), .HAM_W(HAM_W)) u_syn (
    .data (bus.in_data),
    .chk  (bus.in_chk),
    .syn  (raw_syn),
    .par  (raw_par)
  );

  assign s2_load     = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = !s1_valid_reg || s2_load;
  assign out_fire    = out_valid_reg && bus.out_ready;

  // Check positions never match a data position, so they produce an all-zero mask.
  genvar gi;
  for (gi = 0; gi < DATA_W; gi++) begin : g_flip
    localparam int POS = data_pos(gi);
    assign flip_mask[gi] = (s1_syn_reg == HAM_W'(POS));
  end

  assign status_next    = classify_syndrome(s1_par_reg, int'(s1_syn_reg), LAST_POS);
  assign data_next      = (status_next == ST_CORR) ? (s1_data_reg ^ flip_mask) : s1_data_reg;
  assign key_shreg_next = {key_shreg_reg[HAM_W-2:0], key_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_shreg_reg  <= '0;
      active_key_reg <= '0;
    end else begin
      if (key_shift_en) key_shreg_reg <= key_shreg_next;
      if (key_commit)   active_key_reg <= key_shift_en ? key_shreg_next : key_shreg_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_data_reg    <= '0;
      s1_syn_reg     <= '0;
      s1_par_reg     <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_status_reg <= ST_CLEAN;
    end else begin
      if (bus.in_ready) begin
        s1_valid_reg <= bus.in_valid;
        // The key in force at capture travels with the word via the stored syndrome.
        if (bus.in_valid) begin
          s1_data_reg <= bus.in_data;
          s1_syn_reg  <= raw_syn ^ active_key_reg ^ KEY_REF;
          s1_par_reg  <= raw_par;
        end
      end
      if (s2_load) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_data_reg   <= data_next;
          out_status_reg <= status_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
    end else if (cnt_clr) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
    end else if (out_fire) begin
      if (out_status_reg == ST_CORR && corr_cnt_reg != '1)
        corr_cnt_reg <= corr_cnt_reg + CNT_W'(1);
      if (out_status_reg == ST_UNCORR && uncorr_cnt_reg != '1)
        uncorr_cnt_reg <= uncorr_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_status = out_status_reg;
  assign corr_cnt       = corr_cnt_reg;
  assign uncorr_cnt     = uncorr_cnt_reg;
endmodule
